sync_fifo_dir: RTL and testbench

SYNC_FIFO_DIR -- requirements
Module: sync_fifo_dir

---
 rtl/sync_fifo_dir_pkg.sv | 16 +
 rtl/fifo_mem.sv | 35 +++
 rtl/sync_fifo_dir.sv | 89 ++++++++
 tb/tb_sync_fifo_dir.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_dir_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_fifo_dir_pkg : shared sizing constants for sync_fifo_dir        |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
package sync_fifo_dir_pkg;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int ADDRSIZE_DEF   = 4;

  function automatic int fifo_depth(input int addrsize);
    return 1 << addrsize;
  endfunction

  localparam int DEPTH_DEF = fifo_depth(ADDRSIZE_DEF);
endpackage
`default_nettype wire

// File: rtl/fifo_mem.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_mem : DEPTH x DATA_WIDTH storage, one write port, one           |
// | registered read port; array contents are never reset.   rev 1.0     |
// +----------------------------------------------------------------------+
module fifo_mem
  import sync_fifo_dir_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDRSIZE   = ADDRSIZE_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDRSIZE-1:0]   waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDRSIZE-1:0]   raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  localparam int DEPTH = fifo_depth(ADDRSIZE);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Only the output register is reset so rdata comes up as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
endmodule
`default_nettype wire

// File: rtl/sync_fifo_dir.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_fifo_dir : synchronous FIFO, binary pointers plus a direction   |
// | bit to tell full from empty.                              rev 1.0    |
// +----------------------------------------------------------------------+
module sync_fifo_dir
  import sync_fifo_dir_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDRSIZE   = ADDRSIZE_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rdata,
  input  logic [ADDRSIZE:0]     afull_thr,
  input  logic [ADDRSIZE:0]     aempty_thr,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDRSIZE:0]     count,
  output logic                  overflow,
  output logic                  underflow
);
  logic [ADDRSIZE-1:0] wptr;
  logic [ADDRSIZE-1:0] rptr;
  logic                direction;
  logic                ptr_eq;
  logic                rd_acc;
  logic                wr_acc;

  assign ptr_eq       = (wptr == rptr);
  assign full         = ptr_eq & direction;
  assign empty        = ptr_eq & ~direction;
  // A read frees a slot in the same cycle, so a full FIFO still takes a write.
  assign rd_acc       = rd_en & ~empty & ~clr;
  assign wr_acc       = wr_en & (~full | rd_acc) & ~clr;
  assign almost_full  = (count >= afull_thr);
  assign almost_empty = (count <= aempty_thr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr      <= '0;
      rptr      <= '0;
      direction <= 1'b0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clr) begin
      wptr      <= '0;
      rptr      <= '0;
      direction <= 1'b0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wptr <= wptr + ADDRSIZE'(1);
      if (rd_acc) rptr <= rptr + ADDRSIZE'(1);
      if (wr_acc && !rd_acc) begin
        direction <= 1'b1;
        count     <= count + (ADDRSIZE + 1)'(1);
      end else if (rd_acc && !wr_acc) begin
        direction <= 1'b0;
        count     <= count - (ADDRSIZE + 1)'(1);
      end
      if (wr_en && full && !rd_acc) overflow  <= 1'b1;
      if (rd_en && empty)           underflow <= 1'b1;
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDRSIZE   (ADDRSIZE)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_acc),
    .waddr (wptr),
    .wdata (wdata),
    .re    (rd_acc),
    .raddr (rptr),
    .rdata (rdata)
  );
endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_dir.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sync_fifo_dir : vector table, directed corners and random traffic |
// | against a queue-based reference.                          rev 1.0    |
// +----------------------------------------------------------------------+
module tb_sync_fifo_dir;
  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clr;
  logic          wr_en;
  logic [DW-1:0] wdata;
  logic          rd_en;
  logic [DW-1:0] rdata;
  logic [AW:0]   afull_thr;
  logic [AW:0]   aempty_thr;
  logic          full, empty, almost_full, almost_empty;
  logic [AW:0]   count;
  logic          overflow, underflow;

  int errors = 0;
  int checks = 0;

  // Reference: contents as a queue, sticky flags and last read word.
  logic [DW-1:0] q[$];
  logic          m_ovf, m_unf;
  logic [DW-1:0] m_rdata;

  typedef struct {
    logic          wr, rd, cl;
    logic [DW-1:0] d;
    int            cnt;
    logic          f, e, ovf, unf;
    logic [DW-1:0] rd_exp;
  } vec_t;
  vec_t vecs[7];

  always #5 clk = ~clk;

  sync_fifo_dir #(.DATA_WIDTH(DW), .ADDRSIZE(AW)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wdata(wdata),
    .rd_en(rd_en), .rdata(rdata), .afull_thr(afull_thr), .aempty_thr(aempty_thr),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 1'b0; m_unf = 1'b0; m_rdata = '0;
  endtask

  task automatic model_step();
    bit rd_ok, wr_ok;
    int n;
    n = q.size();
    if (clr) begin
      q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    end else begin
      rd_ok = rd_en && n > 0;
      wr_ok = wr_en && (n < DEPTH || rd_ok);
      if (rd_en && n == 0) m_unf = 1'b1;
      if (wr_en && n == DEPTH && !rd_ok) m_ovf = 1'b1;
      if (rd_ok) m_rdata = q.pop_front();
      if (wr_ok) q.push_back(wdata);
    end
  endtask

  task automatic model_cmp();
    int n;
    n = q.size();
    chk("count", int'(count), n);
    chk("full", int'(full), int'(n == DEPTH));
    chk("empty", int'(empty), int'(n == 0));
    chk("almost_full", int'(almost_full), int'(n >= int'(afull_thr)));
    chk("almost_empty", int'(almost_empty), int'(n <= int'(aempty_thr)));
    chk("overflow", int'(overflow), int'(m_ovf));
    chk("underflow", int'(underflow), int'(m_unf));
    chk("rdata", int'(rdata), int'(m_rdata));
  endtask

  task automatic cycle(input logic w, input logic r, input logic c, input logic [DW-1:0] d);
    wr_en = w; rd_en = r; clr = c; wdata = d;
    model_step();
    @(posedge clk); #1;
    model_cmp();
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b1, 1'b0, 8'hA5, 1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA5};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA5};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 8'h77, 0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 8'h3C, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 8'h5A, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h5A};

    rst_n = 1'b0; clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wdata = '0;
    afull_thr = 5'd16; aempty_thr = 5'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_count", int'(count), 0);
    chk("reset_empty", int'(empty), 1);
    chk("reset_full", int'(full), 0);
    chk("reset_rdata", int'(rdata), 0);
    @(negedge clk) rst_n = 1'b1;

    // Simultaneous ops on empty, underflow, clr override, rdata hold.
    for (int i = 0; i < 7; i++) begin
      cycle(vecs[i].wr, vecs[i].rd, vecs[i].cl, vecs[i].d);
      chk($sformatf("vec%0d_count", i), int'(count), vecs[i].cnt);
      chk($sformatf("vec%0d_full", i), int'(full), int'(vecs[i].f));
      chk($sformatf("vec%0d_empty", i), int'(empty), int'(vecs[i].e));
      chk($sformatf("vec%0d_ovf", i), int'(overflow), int'(vecs[i].ovf));
      chk($sformatf("vec%0d_unf", i), int'(underflow), int'(vecs[i].unf));
      chk($sformatf("vec%0d_rdata", i), int'(rdata), int'(vecs[i].rd_exp));
    end
    cycle(1'b0, 1'b0, 1'b1, 8'h00);

    // Fill then drain in order.
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 1'b0, 1'b0, DW'(i));
      chk("fill_count", int'(count), i + 1);
    end
    chk("fill_full", int'(full), 1);
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 8'h00);
      chk("drain_data", int'(rdata), i);
    end
    chk("drain_empty", int'(empty), 1);

    // Overflow is sticky and leaves contents intact; clr wipes it.
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 1'b0, DW'(8'h40 + i));
    cycle(1'b1, 1'b0, 1'b0, 8'hEE);
    chk("ovf_set", int'(overflow), 1);
    chk("ovf_count", int'(count), 16);
    cycle(1'b0, 1'b0, 1'b0, 8'h00);
    chk("ovf_sticky", int'(overflow), 1);
    cycle(1'b0, 1'b1, 1'b0, 8'h00);
    chk("ovf_data", int'(rdata), 8'h40);
    cycle(1'b0, 1'b0, 1'b1, 8'h00);
    chk("clr_count", int'(count), 0);
    chk("clr_empty", int'(empty), 1);
    chk("clr_ovf", int'(overflow), 0);

    // Full with concurrent read/write across pointer wrap.
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 1'b0, DW'(i));
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b1, 1'b0, DW'(16 + i));
      chk("rw_full", int'(full), 1);
      chk("rw_count", int'(count), 16);
      chk("rw_data", int'(rdata), i);
    end

    // Threshold flags while filling, then an async reset mid-stream.
    cycle(1'b0, 1'b0, 1'b1, 8'h00);
    afull_thr = 5'd12; aempty_thr = 5'd3;
    for (int k = 1; k <= 14; k++) begin
      cycle(1'b1, 1'b0, 1'b0, DW'(k));
      chk("thr_afull", int'(almost_full), int'(k >= 12));
      chk("thr_aempty", int'(almost_empty), int'(k <= 3));
    end
    wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_count", int'(count), 0);
    chk("arst_empty", int'(empty), 1);
    chk("arst_full", int'(full), 0);
    chk("arst_rdata", int'(rdata), 0);
    chk("arst_afull", int'(almost_full), 0);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Random traffic with shifting read/write bias.
    for (int i = 0; i < 3000; i++) begin
      int wp, rp;
      logic w, r, c;
      if (i % 100 == 0) begin
        afull_thr  = AW'($urandom_range(0, 16));
        aempty_thr = AW'($urandom_range(0, 16));
      end
      wp = ((i / 400) % 2 == 0) ? 75 : 30;
      rp = 105 - wp;
      w  = ($urandom_range(0, 99) < wp);
      r  = ($urandom_range(0, 99) < rp);
      c  = ($urandom_range(0, 299) == 0);
      cycle(w, r, c, DW'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
